// File: rtl/tanh_backward.sv
// tanh_backward: backward pass of the tanh activation, grad_output = grad_in * (1 - y^2), signed Q2.14.
// Three register stages, one sample accepted per cycle, result_valid follows en by three cycles.
module tanh_backward #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] tanh_y,
   input  logic [WIDTH-1:0] grad_in,
   output logic             result_valid,
   output logic [WIDTH-1:0] grad_output
);

   localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1 << FRAC);
   localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;

   logic signed [WIDTH-1:0]   w_y;
   logic signed [WIDTH-1:0]   w_yClamp;
   logic signed [2*WIDTH-1:0] w_yWide;
   logic signed [2*WIDTH-1:0] w_sqProd;
   logic signed [2*WIDTH-1:0] w_sqShift;
   logic        [WIDTH-1:0]   w_sq;
   logic        [WIDTH-1:0]   w_d;
   logic signed [2*WIDTH-1:0] w_gWide;
   logic signed [2*WIDTH-1:0] w_dWide;
   logic signed [2*WIDTH-1:0] w_pProd;
   logic signed [2*WIDTH-1:0] w_pShift;

   logic [2:0]       r_v;
   logic [WIDTH-1:0] r_sq;
   logic [WIDTH-1:0] r_g1;
   logic [WIDTH-1:0] r_d;
   logic [WIDTH-1:0] r_g2;
   logic [WIDTH-1:0] r_out;

   // Inputs beyond +/-1.0 are not legal tanh outputs; clamping keeps sq within [0, 1.0].
   always_comb begin
      w_y = $signed(tanh_y);
      if (w_y > ONE)
         w_yClamp = ONE;
      else if (w_y < NEG_ONE)
         w_yClamp = NEG_ONE;
      else
         w_yClamp = w_y;
   end

   assign w_yWide   = (2*WIDTH)'(w_yClamp);
   assign w_sqProd  = w_yWide * w_yWide;
   assign w_sqShift = w_sqProd >>> FRAC;
   assign w_sq      = w_sqShift[WIDTH-1:0];

   assign w_d = ONE - r_sq;

   // d never exceeds 1.0, so the scaled product cannot overflow the output word.
   assign w_gWide  = (2*WIDTH)'($signed(r_g2));
   assign w_dWide  = (2*WIDTH)'($signed(r_d));
   assign w_pProd  = w_gWide * w_dWide;
   assign w_pShift = w_pProd >>> FRAC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v   <= '0;
         r_sq  <= '0;
         r_g1  <= '0;
         r_d   <= '0;
         r_g2  <= '0;
         r_out <= '0;
      end else begin
         r_v <= {r_v[1:0], en};
         if (en) begin
            r_sq <= w_sq;
            r_g1 <= grad_in;
         end
         if (r_v[0]) begin
            r_d  <= w_d;
            r_g2 <= r_g1;
         end
         if (r_v[1])
            r_out <= w_pShift[WIDTH-1:0];
      end
   end

   assign result_valid = r_v[2];
   assign grad_output  = r_out;

endmodule

// File: tb/tb_tanh_backward.sv
// Self-checking bench for tanh_backward: directed spec vectors, streaming, reset cases and
// randomized traffic compared against an arithmetic reference model.
module tb_tanh_backward;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [15:0] tanh_y;
   logic [15:0] grad_in;
   logic        result_valid;
   logic [15:0] grad_output;

   int checks   = 0;
   int failures = 0;
   int edgeCount = 0;

   typedef struct {
      int          due;
      logic [15:0] data;
   } exp_t;

   exp_t        pending[$];
   logic [15:0] lastExp = 16'h0000;

   tanh_backward #(.WIDTH(16), .FRAC(14)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .tanh_y       (tanh_y),
      .grad_in      (grad_in),
      .result_valid (result_valid),
      .grad_output  (grad_output)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edgeCount <= edgeCount + 1;

   // Reference: g * (1 - y^2) on plain integers, y limited to +/-1.0.
   function automatic logic [15:0] refGrad(input logic [15:0] y, input logic [15:0] g);
      int yi;
      int gi;
      int sq;
      int p;
      yi = $signed(y);
      gi = $signed(g);
      if (yi > 16384) yi = 16384;
      if (yi < -16384) yi = -16384;
      sq = (yi * yi) / 16384;
      p  = (gi * (16384 - sq)) >>> 14;
      return p[15:0];
   endfunction

   // Drives one cycle from a negedge, then reports what the model expects at the next negedge.
   task automatic applyStimulus(input bit e, input logic [15:0] y, input logic [15:0] g,
                                output bit expV, output logic [15:0] expD);
      en      = e;
      tanh_y  = y;
      grad_in = g;
      if (e) pending.push_back('{edgeCount + 3, refGrad(y, g)});
      @(negedge clk);
      expV = 1'b0;
      if (pending.size() > 0 && pending[0].due == edgeCount) begin
         expV    = 1'b1;
         lastExp = pending[0].data;
         void'(pending.pop_front());
      end
      expD = lastExp;
   endtask

   task automatic test_reset();
      bit          v;
      logic [15:0] d;
      rst_n = 1'b0; en = 1'b0; tanh_y = '0; grad_in = '0;
      repeat (2) @(negedge clk);
      checks++;
      if (result_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL reset_valid got=%b exp=0", result_valid);
      end
      checks++;
      if (grad_output !== 16'h0000) begin
         failures++; $display("[TB] FAIL reset_data got=%h exp=0000", grad_output);
      end
      rst_n = 1'b1;
      applyStimulus(1'b1, 16'h2000, 16'h4000, v, d);
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(1'b0, 16'h0000, 16'h0000, v, d);
         checks++;
         if (result_valid !== (c == 2)) begin
            failures++; $display("[TB] FAIL first_en_valid c=%0d got=%b exp=%b", c, result_valid, (c == 2));
         end
      end
      checks++;
      if (grad_output !== 16'h3000) begin
         failures++; $display("[TB] FAIL first_en_data got=%h exp=3000", grad_output);
      end
   endtask

   task automatic test_directed();
      logic [15:0] vec[8][3];
      bit          v;
      logic [15:0] d;
      vec = '{'{16'h0000, 16'h4000, 16'h4000}, '{16'h2000, 16'h4000, 16'h3000},
              '{16'hE000, 16'h4000, 16'h3000}, '{16'h7FFF, 16'h1234, 16'h0000},
              '{16'h8000, 16'h1234, 16'h0000}, '{16'h4000, 16'h7FFF, 16'h0000},
              '{16'h2000, 16'hFFFF, 16'hFFFF}, '{16'h0000, 16'h8000, 16'h8000}};
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, vec[i][0], vec[i][1], v, d);
         for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b0, 16'h0000, 16'h0000, v, d);
            checks++;
            if (result_valid !== (c == 2)) begin
               failures++;
               $display("[TB] FAIL directed_valid vec=%0d c=%0d got=%b exp=%b", i, c, result_valid, (c == 2));
            end
            if (c >= 2) begin
               checks++;
               if (grad_output !== vec[i][2]) begin
                  failures++;
                  $display("[TB] FAIL directed_data vec=%0d y=%h g=%h c=%0d got=%h exp=%h",
                           i, vec[i][0], vec[i][1], c, grad_output, vec[i][2]);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bit          enSeq[10]  = '{1, 1, 1, 1, 0, 1, 0, 0, 0, 0};
      logic [15:0] ySeq[10]   = '{16'h0000, 16'h2000, 16'h4000, 16'h0000, 16'h0000,
                                  16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      logic [15:0] gSeq[10]   = '{16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h0000,
                                  16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
      bit          vExp[10]   = '{0, 0, 1, 1, 1, 1, 0, 1, 0, 0};
      logic [15:0] dExp[10]   = '{16'h0000, 16'h0000, 16'h4000, 16'h3000, 16'h0000,
                                  16'h4000, 16'h4000, 16'h1000, 16'h1000, 16'h1000};
      bit          v;
      logic [15:0] d;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(enSeq[i], ySeq[i], gSeq[i], v, d);
         checks++;
         if (result_valid !== vExp[i]) begin
            failures++; $display("[TB] FAIL stream_valid i=%0d got=%b exp=%b", i, result_valid, vExp[i]);
         end
         if (i >= 2) begin
            checks++;
            if (grad_output !== dExp[i]) begin
               failures++; $display("[TB] FAIL stream_data i=%0d got=%h exp=%h", i, grad_output, dExp[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      bit          v;
      logic [15:0] d;
      logic [15:0] y;
      logic [15:0] g;
      bit          e;
      for (int i = 0; i < 303; i++) begin
         e = (i < 300) && ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1)
            y = 16'($urandom);
         else
            y = 16'($urandom_range(0, 32768) - 16384);
         g = 16'($urandom);
         applyStimulus(e, y, g, v, d);
         checks++;
         if (result_valid !== v) begin
            failures++; $display("[TB] FAIL random_valid i=%0d got=%b exp=%b", i, result_valid, v);
         end
         checks++;
         if (grad_output !== d) begin
            failures++; $display("[TB] FAIL random_data i=%0d got=%h exp=%h", i, grad_output, d);
         end
      end
   endtask

   task automatic test_reset_midflight();
      bit          v;
      logic [15:0] d;
      applyStimulus(1'b1, 16'h0000, 16'h4000, v, d);
      repeat (3) applyStimulus(1'b0, 16'h0000, 16'h0000, v, d);
      checks++;
      if (grad_output !== 16'h4000) begin
         failures++; $display("[TB] FAIL midflight_pre got=%h exp=4000", grad_output);
      end
      applyStimulus(1'b1, 16'h2000, 16'h4000, v, d);
      applyStimulus(1'b1, 16'h0000, 16'h1000, v, d);
      en = 1'b0;
      rst_n = 1'b0;
      pending.delete();
      lastExp = 16'h0000;
      #1;
      checks++;
      if (result_valid !== 1'b0 || grad_output !== 16'h0000) begin
         failures++;
         $display("[TB] FAIL midflight_async got=%b/%h exp=0/0000", result_valid, grad_output);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         applyStimulus(1'b0, 16'h0000, 16'h0000, v, d);
         checks++;
         if (result_valid !== 1'b0 || grad_output !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL midflight_quiet c=%0d got=%b/%h exp=0/0000", c, result_valid, grad_output);
         end
      end
      applyStimulus(1'b1, 16'h2000, 16'h4000, v, d);
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(1'b0, 16'h0000, 16'h0000, v, d);
         checks++;
         if (result_valid !== (c == 2)) begin
            failures++; $display("[TB] FAIL midflight_next_valid c=%0d got=%b exp=%b", c, result_valid, (c == 2));
         end
      end
      checks++;
      if (grad_output !== 16'h3000) begin
         failures++; $display("[TB] FAIL midflight_next_data got=%h exp=3000", grad_output);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
